// File: rtl/morse_code_decoder.sv
// Morse receive stage: synchronizes the LED line, times marks and spaces,
// collects five dot/dash symbols and emits the decoded digit or an error strobe.
module morse_code_decoder #(
  parameter int unsigned CLK_HZ           = 100_000_000,
  parameter int unsigned DOT_LEN          = CLK_HZ,
  parameter int unsigned GLITCH_LEN       = DOT_LEN / 4,
  parameter int unsigned DOT_DASH_THRESH  = 2 * CLK_HZ,
  parameter int unsigned DIGIT_END_THRESH = 5 * CLK_HZ,
  parameter int unsigned MAX_MARK         = 6 * CLK_HZ,
  parameter int unsigned CNT_W            = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       morse_in,
  output logic [3:0] digit_out,
  output logic       digit_valid,
  output logic       digit_error,
  output logic       busy
);

  localparam logic [CNT_W-1:0] GLITCH_C = CNT_W'(GLITCH_LEN);
  localparam logic [CNT_W-1:0] DASH_C   = CNT_W'(DOT_DASH_THRESH);
  localparam logic [CNT_W-1:0] END_C    = CNT_W'(DIGIT_END_THRESH);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_MARK);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, MARK, SPACE, EMIT, WAIT_LOW} state_t;

  state_t           state, state_n;
  logic [1:0]       sync_q;
  logic             s;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [4:0]       sym, sym_n;
  logic [2:0]       nsym, nsym_n;
  logic [3:0]       digit_n;
  logic             valid_n, error_n;
  logic             dec_ok;
  logic [3:0]       dec_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], morse_in};
  end

  assign s       = sync_q[1];
  assign cnt_inc = (&cnt) ? cnt : cnt + ONE_C;
  assign busy    = (state != IDLE);

  // First symbol sits in bit 4; a 1 is a dash.
  always_comb begin
    dec_ok  = 1'b1;
    dec_val = '0;
    case (sym)
      5'b11111: dec_val = 4'd0;
      5'b01111: dec_val = 4'd1;
      5'b00111: dec_val = 4'd2;
      5'b00011: dec_val = 4'd3;
      5'b00001: dec_val = 4'd4;
      5'b00000: dec_val = 4'd5;
      5'b10000: dec_val = 4'd6;
      5'b11000: dec_val = 4'd7;
      5'b11100: dec_val = 4'd8;
      5'b11110: dec_val = 4'd9;
      default:  dec_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sym_n   = sym;
    nsym_n  = nsym;
    digit_n = digit_out;
    valid_n = 1'b0;
    error_n = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          state_n = MARK;
          cnt_n   = ONE_C;
        end
      end
      MARK: begin
        if (cnt >= MAX_C) begin
          error_n = 1'b1;
          sym_n   = '0;
          nsym_n  = '0;
          cnt_n   = '0;
          state_n = WAIT_LOW;
        end else if (s) begin
          cnt_n = cnt_inc;
        end else if (cnt < GLITCH_C) begin
          cnt_n   = ONE_C;
          state_n = (nsym != 3'd0) ? SPACE : IDLE;
        end else begin
          sym_n   = {sym[3:0], (cnt >= DASH_C)};
          nsym_n  = (nsym == 3'd6) ? nsym : nsym + 3'd1;
          cnt_n   = ONE_C;
          state_n = SPACE;
        end
      end
      SPACE: begin
        if (s) begin
          cnt_n   = ONE_C;
          state_n = MARK;
        end else if (cnt >= END_C) begin
          state_n = EMIT;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      EMIT: begin
        if (nsym == 3'd5 && dec_ok) begin
          digit_n = dec_val;
          valid_n = 1'b1;
        end else begin
          error_n = 1'b1;
        end
        sym_n   = '0;
        nsym_n  = '0;
        cnt_n   = '0;
        state_n = IDLE;
      end
      WAIT_LOW: begin
        if (!s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      sym         <= '0;
      nsym        <= '0;
      digit_out   <= '0;
      digit_valid <= 1'b0;
      digit_error <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      sym         <= sym_n;
      nsym        <= nsym_n;
      digit_out   <= digit_n;
      digit_valid <= valid_n;
      digit_error <= error_n;
    end
  end

endmodule

// File: tb/tb_morse_code_decoder.sv
// Scoreboard bench for morse_code_decoder: directed scenarios plus random codes
// checked against a table-driven model of the digit code book and strobe timing.
module tb_morse_code_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       morse_in = 1'b0;
  logic [3:0] digit_out;
  logic       digit_valid, digit_error, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int rise_cyc = 0;
  int model_digit = 0;

  typedef struct {
    bit err;
    int dig;
    int at;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  morse_code_decoder #(
    .CLK_HZ(4),
    .DOT_LEN(4),
    .GLITCH_LEN(2),
    .DOT_DASH_THRESH(8),
    .DIGIT_END_THRESH(20),
    .MAX_MARK(24),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .morse_in(morse_in),
    .digit_out(digit_out),
    .digit_valid(digit_valid),
    .digit_error(digit_error),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Symbol k (k=0 sent first) is a dash: digits 0-5 lead with d dots, 6-9 with d-5 dashes.
  function automatic bit [5:0] code_of(input int d);
    bit [5:0] b;
    b = '0;
    for (int k = 0; k < 5; k++) b[k] = (d <= 5) ? (k >= d) : (k < d - 5);
    return b;
  endfunction

  function automatic int decode_model(input int n, input bit [5:0] b);
    bit [5:0] c;
    if (n != 5) return -1;
    for (int d = 0; d < 10; d++) begin
      c = code_of(d);
      if (c[4:0] == b[4:0]) return d;
    end
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic hold(input bit v, input int n);
    @(negedge clk);
    if (morse_in && !v) fall_cyc = cyc + 1;
    if (!morse_in && v) rise_cyc = cyc + 1;
    morse_in = v;
    repeat (n - 1) @(negedge clk);
  endtask

  // gmode: 0 no glitches, 1 random glitches in gaps, 2 glitch in the second gap
  task automatic send_code(input int n, input bit [5:0] b, input bit fixed,
                           input int gmode, input string name);
    int len;
    int d;
    for (int i = 0; i < n; i++) begin
      len = b[i] ? (fixed ? 12 : int'($urandom_range(9, 14)))
                 : (fixed ? 4 : int'($urandom_range(3, 6)));
      hold(1'b1, len);
      if (i < n - 1) begin
        if ((gmode == 2 && i == 1) || (gmode == 1 && $urandom_range(0, 3) == 0)) begin
          hold(1'b0, 2);
          hold(1'b1, 1);
          hold(1'b0, 2);
        end else begin
          hold(1'b0, fixed ? 2 : int'($urandom_range(2, 6)));
        end
      end
    end
    hold(1'b0, 1);
    d = decode_model(n, b);
    if (d < 0) begin
      sb.push_back('{1'b1, model_digit, fall_cyc + 23});
    end else begin
      sb.push_back('{1'b0, d, fall_cyc + 23});
      model_digit = d;
    end
    hold(1'b0, 39);
    check({name, " busy_idle"}, int'(busy), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (digit_valid && digit_error) begin
        checks++;
        errors++;
        $display("FAIL strobe_overlap: valid=%0d error=%0d required not both", digit_valid, digit_error);
      end
      if (digit_valid || digit_error) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: valid=%0d error=%0d digit=%0d at cycle %0d, none expected",
                   digit_valid, digit_error, digit_out, cyc);
        end else begin
          e = sb.pop_front();
          if (digit_error != e.err || int'(digit_out) != e.dig || cyc != e.at) begin
            errors++;
            $display("FAIL strobe: got err=%0d digit=%0d cycle=%0d expected err=%0d digit=%0d cycle=%0d",
                     digit_error, digit_out, cyc, e.err, e.dig, e.at);
          end
        end
      end
    end
  end

  initial begin
    int r;
    int n;
    bit [5:0] b;
    #1;
    check("reset digit_out", int'(digit_out), 0);
    check("reset digit_valid", int'(digit_valid), 0);
    check("reset digit_error", int'(digit_error), 0);
    check("reset busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold(1'b0, 5);

    send_code(5, code_of(0), 1'b1, 0, "digit0");
    send_code(5, code_of(7), 1'b1, 0, "digit7");
    send_code(5, code_of(3), 1'b1, 0, "digit3");
    send_code(3, 6'b000000, 1'b1, 0, "malformed");

    hold(1'b1, 1);
    sb.push_back('{1'b1, model_digit, rise_cyc + 26});
    hold(1'b1, 29);
    hold(1'b0, 10);
    check("stuck busy_idle", int'(busy), 0);
    send_code(5, code_of(5), 1'b1, 0, "digit5");
    send_code(5, code_of(9), 1'b1, 2, "digit9_glitch");

    for (int i = 0; i < 3; i++) begin
      hold(1'b1, 4);
      hold(1'b0, 2);
    end
    @(negedge clk);
    rst_n = 1'b0;
    model_digit = 0;
    #1;
    check("midreset digit_out", int'(digit_out), 0);
    check("midreset digit_valid", int'(digit_valid), 0);
    check("midreset digit_error", int'(digit_error), 0);
    check("midreset busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    hold(1'b0, 40);
    send_code(5, code_of(4), 1'b1, 0, "digit4_after_reset");

    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 3));
      if (r <= 1) begin
        n = 5;
        b = code_of(int'($urandom_range(0, 9)));
      end else if (r == 2) begin
        n = 5;
        b = 6'($urandom);
      end else begin
        n = int'($urandom_range(1, 6));
        b = 6'($urandom);
      end
      send_code(n, b, 1'b0, 1, "random");
    end

    repeat (50) @(negedge clk);
    check("scoreboard drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
